// File: rtl/conv1_maxpool_relu_pkg.sv
// Shared constants for the conv1 -> pool -> conv2 path: pixel width and the
// conv1 / pooled feature-map dimensions.
package conv1_maxpool_relu_pkg;

  localparam int unsigned PIX_BITS = 12;
  localparam int unsigned CONV1_W  = 24;
  localparam int unsigned CONV1_H  = 24;
  localparam int unsigned POOL_W   = CONV1_W / 2;
  localparam int unsigned POOL_H   = CONV1_H / 2;

  typedef logic signed [PIX_BITS-1:0] pixel_t;

endpackage

// File: rtl/conv1_maxpool_relu_if.sv
// Pixel stream into and pooled pixel stream out of one max-pool/ReLU lane.
interface conv1_maxpool_relu_if
  import conv1_maxpool_relu_pkg::*;
#(
  parameter int unsigned DATA_BITS = PIX_BITS
);

  logic                        valid_in;
  logic signed [DATA_BITS-1:0] data_in;
  logic                        valid_out;
  logic signed [DATA_BITS-1:0] data_out;

  modport master (output valid_in, output data_in, input valid_out, input data_out);
  modport slave  (input valid_in, input data_in, output valid_out, output data_out);

endinterface

// File: rtl/conv1_maxpool_relu_signed_max2.sv
// Combinational signed maximum of two pixels; ties return a (same value).
module conv1_maxpool_relu_signed_max2
  import conv1_maxpool_relu_pkg::*;
#(
  parameter int unsigned DATA_BITS = PIX_BITS
) (
  input  logic signed [DATA_BITS-1:0] a,
  input  logic signed [DATA_BITS-1:0] b,
  output logic signed [DATA_BITS-1:0] max_c
);

  assign max_c = (b > a) ? b : a;

endmodule

// File: rtl/conv1_maxpool_relu.sv
// Streaming 2x2 stride-2 max-pool with ReLU on one raster-ordered conv1 channel.
module conv1_maxpool_relu
  import conv1_maxpool_relu_pkg::*;
#(
  parameter int unsigned DATA_BITS = PIX_BITS,
  parameter int unsigned IN_WIDTH  = CONV1_W,
  parameter int unsigned IN_HEIGHT = CONV1_H
) (
  input logic                 clk,
  input logic                 rst_n,
  conv1_maxpool_relu_if.slave bus
);

  localparam int unsigned COL_BITS = $clog2(IN_WIDTH);
  localparam int unsigned ROW_BITS = $clog2(IN_HEIGHT);
  localparam int unsigned IDX_BITS = COL_BITS - 1;
  localparam int unsigned PAIRS    = IN_WIDTH / 2;

  logic [COL_BITS-1:0]         col;
  logic [ROW_BITS-1:0]         row;
  logic [IDX_BITS-1:0]         pair_idx;
  logic signed [DATA_BITS-1:0] hold;
  logic signed [DATA_BITS-1:0] line_buf [PAIRS];
  logic signed [DATA_BITS-1:0] above;
  logic signed [DATA_BITS-1:0] pair_c;
  logic signed [DATA_BITS-1:0] win_max_c;
  logic signed [DATA_BITS-1:0] data_out_q;
  logic                        valid_out_q;
  logic                        col_last;
  logic                        row_last;
  logic                        line_wr;
  logic                        pool_fire;

  assign pair_idx  = col[COL_BITS-1:1];
  assign above     = line_buf[pair_idx];
  assign col_last  = (col == COL_BITS'(IN_WIDTH - 1));
  assign row_last  = (row == ROW_BITS'(IN_HEIGHT - 1));
  assign line_wr   = rst_n & bus.valid_in & col[0] & ~row[0];
  assign pool_fire = bus.valid_in & col[0] & row[0];

  // Horizontal compare of the held even pixel with the current odd pixel
  conv1_maxpool_relu_signed_max2 #(.DATA_BITS(DATA_BITS)) u_hmax (
    .a     (hold),
    .b     (bus.data_in),
    .max_c (pair_c)
  );

  // Vertical compare of the stored even-row pair with the odd-row pair
  conv1_maxpool_relu_signed_max2 #(.DATA_BITS(DATA_BITS)) u_vmax (
    .a     (above),
    .b     (pair_c),
    .max_c (win_max_c)
  );

  // Raster position; only advances on accepted pixels so gaps are transparent
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (bus.valid_in) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + ROW_BITS'(1);
      end else begin
        col <= col + COL_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (bus.valid_in && !col[0]) begin
      hold <= bus.data_in;
    end
  end

  // Even rows always refill every entry before the odd row reads it, so no reset
  always_ff @(posedge clk) begin
    if (line_wr) begin
      line_buf[pair_idx] <= pair_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      valid_out_q <= pool_fire;
      if (pool_fire) begin
        data_out_q <= win_max_c[DATA_BITS-1] ? '0 : win_max_c;
      end
    end
  end

  assign bus.valid_out = valid_out_q;
  assign bus.data_out  = data_out_q;

endmodule

// File: doc/conv1_maxpool_relu.md
# conv1_maxpool_relu

- Streaming 2×2 max-pool (stride 2) with ReLU, placed between the first convolution layer and `conv2_buf`.
- Consumes one channel of the 24×24 signed conv1 feature map in raster order, one pixel per `valid_in` cycle.
- Emits the 12×12 pooled, rectified map in raster order, which is exactly the stream `conv2_buf` expects.
- One instance per conv1 channel.

## Interface
Parameters:
- `DATA_BITS`, 12: pixel width, two's-complement signed, same on input and output.
- `IN_WIDTH`, 24: input row length, even.
- `IN_HEIGHT`, 24: input rows per frame, even.

Ports:
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `valid_in` input 1: `data_in` carries the next raster pixel this cycle.
- `data_in` input `DATA_BITS`: signed conv1 pixel.
- `data_out` output `DATA_BITS`: pooled, rectified pixel, registered.
- `valid_out` output 1: one-cycle qualifier for `data_out`, registered.

## Operation
- Counters:
  - `col`: 0..`IN_WIDTH`-1, 5 bits at defaults.
  - `row`: 0..`IN_HEIGHT`-1.
  - Both advance only on `valid_in` cycles.
  - `col` wraps to 0 at `IN_WIDTH`-1 and increments `row`.
  - `row` wraps to 0 after the last pixel of the frame. No inter-frame state remains, so the next frame starts immediately.
- Horizontal pair:
  - Even `col`: latch `data_in` into `hold`.
  - Odd `col`: `pair = smax(hold, data_in)`.
- Even `row`, odd `col`: write `pair` into `line_buf[col>>1]`. `line_buf` has `IN_WIDTH`/2 entries.
- Odd `row`, odd `col`:
  - `m = smax(line_buf[col>>1], pair)`.
  - `data_out <= m[MSB] ? 0 : m` (ReLU).
  - `valid_out <= 1`.
- All other cycles: `valid_out <= 0`. `data_out` holds its last value.
- `smax` is a signed comparison. Ties return either operand; the values are identical.
- No saturation or width change. Output is always ≥ 0 and below 2^(`DATA_BITS`-1).
- Gaps: `valid_in` may drop for any number of cycles at any position. All state holds; pairing and row parity are unaffected.
- No backpressure: the downstream stage must accept every `valid_out` pulse.
- Per frame: exactly `IN_WIDTH`·`IN_HEIGHT`/4 pulses, 144 at defaults.

## Timing
- Reset (`rst_n` low at a rising edge):
  - `col`, `row`, `hold` go to 0.
  - `valid_out` goes to 0; `data_out` goes to 0.
  - `line_buf` is not reset. It is always written on an even row before it is read.
- Reset mid-frame aborts the partial frame: no further pulses for it. The first `valid_in` after release is pixel (0,0).
- Reset has priority over `valid_in` in the same cycle.
- Latency: the pixel at (odd row, odd col) sampled at edge N yields `valid_out`=1 and `data_out` valid after edge N, i.e. for the whole cycle N..N+1. 1-cycle latency.
- Back-to-back output pulses are impossible: at least one even-column input separates them. At full rate `valid_out` toggles every cycle during odd rows.
- Last output of a frame is pooled pixel (11,11) at defaults. It follows input pixel (23,23) by 1 cycle, with no flush needed.

## Structure
- Shared package/header holds:
  - `DATA_BITS` (shared with `conv2_buf`).
  - Conv1 output dims 24×24.
  - Pooled dims 12×12 (= `conv2_buf` `WIDTH`/`HEIGHT`).
- One natural sub-module: `signed_max2`. Combinational, two `DATA_BITS` signed inputs, one output; instantiated twice (horizontal and vertical compare).
- `line_buf` is a plain register array; no RAM macro at 12 entries.

## Test plan
- Ramp frame, full rate: input pixel (r,c) = r·24+c, masked to 12 bits, signed.
  - Required: 144 pulses.
  - Output k = (2·(k/12)+1)·24 + 2·(k%12)+1, as a signed 12-bit value, zeroed if negative. E.g. out0=25, out1=27, out12=73.
- All-negative frame, every pixel = −5 (0xFFB): 144 pulses, all `data_out`=0.
- Mixed window: window 0 = {−3, 7, 100, −2048}, remainder 0.
  - Required: out0=100.
  - Window 0 = {−1, −2, −3, −4}: out0=0.
  - Window 0 = {2047, 0, 0, 0}: out0=2047.
- Random `valid_in` gaps (≈40% idle) on the ramp frame: identical output sequence to the full-rate case, and each pulse 1 cycle after its odd/odd input.
- Reset at input pixel (13,9): no pulses until a new frame is driven. The new ramp frame then produces the exact 144-value reference sequence.
- Two frames back-to-back with no gap: 288 pulses. The second frame's out0 uses only second-frame data, with no bleed from frame 1's `hold`/`line_buf`.
